sync_send: RTL and testbench

SYNC_SEND -- requirements
Module: sync_send

---
 rtl/sync_send.sv | 170 +++++++++++++++++
 tb/tb_sync_send.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_send.sv
// Sync frame sender: copies FRAME_LEN bytes from the AFPGA read port into the
// link tx buffer, then requests transmission and waits for the link ack.
module sync_send #(
  parameter logic [22:0] BASE_ADDR = 23'h300002,
  parameter logic [11:0] FRAME_LEN = 12'd2048,
  parameter logic [15:0] ACK_TMO   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_send_en,
  input  logic [1:0]  sync_atob_en,
  input  logic [7:0]  slink_rd_data,
  input  logic        slink_tx_ack,
  output logic        slink_rd_en,
  output logic [22:0] slink_raddr,
  output logic        slink_tx_wen,
  output logic [10:0] slink_tx_address,
  output logic [7:0]  slink_tx_data,
  output logic        slink_tx_req,
  output logic        sync_send_busy,
  output logic        sync_send_done,
  output logic        sync_send_err
);

  localparam int RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    REQ   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    en_sh_reg;
  logic [1:0]    atob_reg;
  logic          armed_reg;
  logic          go_reg;
  logic [11:0]   rd_idx_reg, rd_idx_next;
  logic [11:0]   wr_idx_reg;
  logic [15:0]   tmo_cnt_reg, tmo_cnt_next;
  logic          err_reg, err_next;
  logic          tx_wen_reg;
  logic [10:0]   tx_addr_reg;
  logic [7:0]    tx_data_reg;
  logic          in_frame;
  logic          abort;
  logic          rd_issue;
  logic          tmo_hit;
  logic [RD_LAT:0] vchain;

  // armed_reg only sets once en has been seen low, so an enable that is
  // already high when reset releases cannot masquerade as a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sh_reg <= 2'b00;
      atob_reg  <= 2'b00;
      armed_reg <= 1'b0;
      go_reg    <= 1'b0;
    end else begin
      en_sh_reg <= {en_sh_reg[0], sync_send_en};
      atob_reg  <= sync_atob_en;
      armed_reg <= armed_reg | ~sync_send_en;
      go_reg    <= (en_sh_reg == 2'b01) && (atob_reg == 2'b01) && armed_reg;
    end
  end

  assign in_frame = (state_reg == READ) || (state_reg == DRAIN) || (state_reg == REQ);
  assign abort    = in_frame && !sync_send_en;
  assign rd_issue = (state_reg == READ) && sync_send_en;
  assign tmo_hit  = (tmo_cnt_reg == ACK_TMO - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      rd_idx_reg  <= '0;
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_idx_reg  <= rd_idx_next;
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rd_idx_next  = rd_idx_reg;
    tmo_cnt_next = '0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        rd_idx_next = '0;
        if (go_reg) state_next = READ;
      end
      READ: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          rd_idx_next = rd_idx_reg + 12'd1;
          if (rd_idx_reg == FRAME_LEN - 12'd1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_next = IDLE;
        else if (wr_idx_reg == FRAME_LEN) state_next = REQ;
      end
      REQ: begin
        // ack takes priority over a timeout landing in the same cycle
        if (abort) begin
          state_next = IDLE;
        end else if (slink_tx_ack) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 16'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Valid pipe matching the read-data latency of the AFPGA port.
  assign vchain[0] = rd_issue;
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_vpipe
      logic v_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) v_reg <= 1'b0;
        else        v_reg <= vchain[gi] && !abort;
      end
      assign vchain[gi+1] = v_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_reg  <= '0;
      tx_wen_reg  <= 1'b0;
      tx_addr_reg <= '0;
      tx_data_reg <= '0;
    end else begin
      tx_wen_reg <= vchain[RD_LAT] && !abort;
      if (state_reg == IDLE) begin
        wr_idx_reg <= '0;
      end else if (vchain[RD_LAT] && !abort) begin
        wr_idx_reg  <= wr_idx_reg + 12'd1;
        tx_addr_reg <= wr_idx_reg[10:0];
        tx_data_reg <= slink_rd_data;
      end
    end
  end

  assign slink_rd_en      = rd_issue;
  assign slink_raddr      = rd_issue ? (BASE_ADDR + {11'd0, rd_idx_reg}) : 23'd0;
  assign slink_tx_wen     = tx_wen_reg;
  assign slink_tx_address = tx_addr_reg;
  assign slink_tx_data    = tx_data_reg;
  assign slink_tx_req     = (state_reg == REQ) && sync_send_en;
  assign sync_send_busy   = (state_reg != IDLE);
  assign sync_send_done   = (state_reg == DONE);
  assign sync_send_err    = err_reg;

endmodule

// File: tb/tb_sync_send.sv
// Bench for sync_send: directed frames checked every cycle against a
// cycle-schedule model derived from the frame timing rules.
module tb_sync_send;

  localparam logic [22:0] BASE  = 23'h300002;
  localparam longint      N     = 2048;
  localparam longint      TMO   = 16;
  localparam longint      NEVER = 64'sh3fff_ffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        sync_send_en;
  logic [1:0]  sync_atob_en;
  logic [7:0]  slink_rd_data;
  logic        slink_tx_ack;
  logic        slink_rd_en;
  logic [22:0] slink_raddr;
  logic        slink_tx_wen;
  logic [10:0] slink_tx_address;
  logic [7:0]  slink_tx_data;
  logic        slink_tx_req;
  logic        sync_send_busy;
  logic        sync_send_done;
  logic        sync_send_err;

  sync_send #(
    .BASE_ADDR (BASE),
    .FRAME_LEN (12'd2048),
    .ACK_TMO   (16'd16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sync_send_en     (sync_send_en),
    .sync_atob_en     (sync_atob_en),
    .slink_rd_data    (slink_rd_data),
    .slink_tx_ack     (slink_tx_ack),
    .slink_rd_en      (slink_rd_en),
    .slink_raddr      (slink_raddr),
    .slink_tx_wen     (slink_tx_wen),
    .slink_tx_address (slink_tx_address),
    .slink_tx_data    (slink_tx_data),
    .slink_tx_req     (slink_tx_req),
    .sync_send_busy   (sync_send_busy),
    .sync_send_done   (sync_send_done),
    .sync_send_err    (sync_send_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // AFPGA memory: data = addr[7:0], returned two cycles after the read
  logic [7:0] mem_d1 = 8'd0;
  logic [7:0] mem_d2 = 8'd0;
  always @(posedge clk) begin
    mem_d1 <= slink_raddr[7:0];
    mem_d2 <= mem_d1;
  end
  assign slink_rd_data = mem_d2;

  // Frame plan: first read cycle, en-drop cycle, ack cycle, reset cycle
  bit     p_valid = 1'b0;
  longint p_s = NEVER, p_x = NEVER, p_a = NEVER, p_r = NEVER;

  int pin_id = 0, pin_seen = 0;
  int exp_rd, exp_wen, exp_req, exp_done, exp_err;
  int mark_rd, mark_wen, mark_req, mark_done, mark_err;
  int tot_rd = 0, tot_wen = 0, tot_req = 0, tot_done = 0, tot_err = 0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    longint      c, q, req_last, f_last, k;
    logic        acked, pre, live;
    logic        e_rd, e_wen, e_req, e_busy, e_done, e_err;
    logic [22:0] e_ra;
    logic [10:0] e_wa;
    logic [7:0]  e_wd;
    c = cyc;
    e_rd = 1'b0; e_wen = 1'b0; e_req = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    e_ra = '0; e_wa = '0; e_wd = '0;
    if (p_valid && c >= p_s && c < p_r) begin
      q        = p_s + N + 3;
      acked    = (p_a >= q) && (p_a <= q + TMO - 1);
      req_last = acked ? p_a : q + TMO - 1;
      f_last   = acked ? p_a + 1 : q + TMO - 1;
      pre      = (c < p_x);
      live     = (c <= p_x);
      k        = c - p_s - 3;
      e_rd     = pre && (c <= p_s + N - 1);
      e_wen    = live && (k >= 0) && (k < N);
      e_req    = pre && (c >= q) && (c <= req_last);
      e_busy   = live && (c <= f_last);
      e_done   = live && acked && (c == p_a + 1);
      e_err    = !acked && (p_x > q + TMO - 1) && (c == q + TMO);
      if (e_rd)  e_ra = 23'(longint'(BASE) + (c - p_s));
      if (e_wen) begin
        e_wa = 11'(k);
        e_wd = 8'(longint'(BASE) + k);
      end
    end

    chk("rd_en", c, 32'(slink_rd_en), 32'(e_rd));
    chk("tx_wen", c, 32'(slink_tx_wen), 32'(e_wen));
    chk("tx_req", c, 32'(slink_tx_req), 32'(e_req));
    chk("busy", c, 32'(sync_send_busy), 32'(e_busy));
    chk("done", c, 32'(sync_send_done), 32'(e_done));
    chk("err", c, 32'(sync_send_err), 32'(e_err));
    if (!reset || e_rd) chk("raddr", c, 32'(slink_raddr), 32'(e_ra));
    if (!reset || e_wen) begin
      chk("tx_address", c, 32'(slink_tx_address), 32'(e_wa));
      chk("tx_data", c, 32'(slink_tx_data), 32'(e_wd));
    end

    // hand-computed anchors for the default base address and frame length
    if (reset && p_valid) begin
      if (c == p_s && p_x > c && p_r > c)
        chk("pin_first_raddr", c, 32'(slink_raddr), 32'h0030_0002);
      if (c == p_s + 2047 && p_x > c && p_r > c)
        chk("pin_last_raddr", c, 32'(slink_raddr), 32'h0030_0801);
      if (c == p_s + 2 && p_r > c)
        chk("pin_wen_latency", c, 32'(slink_tx_wen), 32'd0);
      if (c == p_s + 3 && p_x >= c && p_r > c) begin
        chk("pin_first_wdata", c, 32'(slink_tx_data), 32'h02);
        chk("pin_first_waddr", c, 32'(slink_tx_address), 32'd0);
      end
      if (c == p_s + 2050 && p_x >= c && p_r > c) begin
        chk("pin_last_wdata", c, 32'(slink_tx_data), 32'h01);
        chk("pin_last_waddr", c, 32'(slink_tx_address), 32'd2047);
      end
    end

    tot_rd   += int'(slink_rd_en);
    tot_wen  += int'(slink_tx_wen);
    tot_req  += int'(slink_tx_req);
    tot_done += int'(sync_send_done);
    tot_err  += int'(sync_send_err);

    if (pin_id != pin_seen) begin
      pin_seen = pin_id;
      chk("count_rd", c, 32'(tot_rd - mark_rd), 32'(exp_rd));
      chk("count_wen", c, 32'(tot_wen - mark_wen), 32'(exp_wen));
      chk("count_req", c, 32'(tot_req - mark_req), 32'(exp_req));
      chk("count_done", c, 32'(tot_done - mark_done), 32'(exp_done));
      chk("count_err", c, 32'(tot_err - mark_err), 32'(exp_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input longint t);
    while (cyc < t) tick(1);
  endtask

  task automatic mark();
    mark_rd = tot_rd; mark_wen = tot_wen; mark_req = tot_req;
    mark_done = tot_done; mark_err = tot_err;
  endtask

  task automatic pin_req(input int rd, input int wen, input int req, input int done, input int err);
    exp_rd = rd; exp_wen = wen; exp_req = req; exp_done = done; exp_err = err;
    pin_id++;
  endtask

  // ack_off < 0: never ack; otherwise ack arrives ack_off cycles after req rises
  task automatic start_frame(input longint ack_off);
    mark();
    p_s = cyc + 3;
    p_a = (ack_off < 0) ? NEVER : cyc + 3 + N + 3 + ack_off;
    p_x = NEVER;
    p_r = NEVER;
    p_valid = 1'b1;
    sync_send_en = 1'b1;
    sync_atob_en = 2'b01;
  endtask

  initial begin
    reset = 1'b0; sync_send_en = 1'b0; sync_atob_en = 2'b00; slink_tx_ack = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);

    // enable with the wrong data-ready code
    mark();
    sync_send_en = 1'b1; sync_atob_en = 2'b10;
    tick(10);
    pin_req(0, 0, 0, 0, 0);
    sync_send_en = 1'b0; sync_atob_en = 2'b00;
    tick(3);
    $display("frame atob=10: no transfer expected, cycle %0d", cyc);

    // full frame, stray ack during reads, ack 10 cycles after req
    start_frame(10);
    wait_until(p_s + 50);
    slink_tx_ack = 1'b1; tick(1); slink_tx_ack = 1'b0;
    wait_until(p_a);
    slink_tx_ack = 1'b1; tick(1); slink_tx_ack = 1'b0;
    wait_until(p_a + 4);
    pin_req(2048, 2048, 11, 1, 0);
    sync_send_en = 1'b0; sync_atob_en = 2'b00;
    tick(3);
    $display("frame full+ack: started cycle %0d, ack cycle %0d", p_s, p_a);

    // abort after 100 reads
    start_frame(10);
    wait_until(p_s + 100);
    p_x = cyc;
    sync_send_en = 1'b0;
    tick(6);
    pin_req(100, 98, 0, 0, 0);
    sync_atob_en = 2'b00;
    tick(3);
    $display("frame abort: started cycle %0d, en dropped cycle %0d", p_s, p_x);

    // no ack: timeout
    start_frame(-1);
    wait_until(p_s + N + 3 + TMO + 4);
    pin_req(2048, 2048, 16, 0, 1);
    sync_send_en = 1'b0; sync_atob_en = 2'b00;
    tick(3);
    $display("frame timeout: started cycle %0d", p_s);

    // asynchronous reset at read 500, en held high through release
    start_frame(-1);
    wait_until(p_s + 500);
    p_r = cyc;
    #1 reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(20);
    pin_req(500, 497, 0, 0, 0);
    sync_send_en = 1'b0;
    tick(2);
    $display("frame reset: started cycle %0d, reset cycle %0d", p_s, p_r);

    // ack in the same cycle the timeout would fire
    start_frame(15);
    wait_until(p_a);
    slink_tx_ack = 1'b1; tick(1); slink_tx_ack = 1'b0;
    wait_until(p_a + 4);
    pin_req(2048, 2048, 16, 1, 0);
    sync_send_en = 1'b0; sync_atob_en = 2'b00;
    tick(3);
    $display("frame ack-at-timeout: started cycle %0d, ack cycle %0d", p_s, p_a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
